// File: rtl/paper_mode_seq.sv
// paper_mode_seq -- sequences a video-mode change on the pixel clock.
//
// A request is accepted in IDLE. The block then waits for a VSync rising
// edge, blanks the output for one cycle, holds the TMDS encoder and
// serializers in reset, loads the new configuration with a single-cycle
// strobe, waits a number of frames for the timing generator to settle,
// and reports completion. Every VSync wait is guarded by a cycle timeout;
// a timeout is treated like an edge and flagged on timeout_o.
//
// Optional feature: define PAPER_MODE_SEQ_ABORT_EN to add input abort_i.
// When abort_i is high while the block waits for the first VSync edge,
// the pending change is dropped and the block returns to IDLE. abort_i
// has no effect in any other state.
//
// Ports:
//   px_clk_i     pixel clock, all logic on its rising edge
//   rst_i        synchronous active-high reset
//   abort_i      (PAPER_MODE_SEQ_ABORT_EN only) abandon a change in WAIT_VS
//   req_valid_i  mode-change request valid
//   req_ready_o  high in IDLE; handshake captures req_cfg_i
//   req_cfg_i    requested configuration word (CfgWidth bits)
//   vsync_i      VSync from the timing generator
//   cfg_o        active configuration to the timing generator
//   cfg_load_o   single-cycle load strobe, coincides with the new cfg_o
//   ser_rst_o    reset to the TMDS encoder and serializers
//   blank_o      forces the video output to blank
//   busy_o       a change is in progress
//   done_o       one-cycle completion pulse
//   timeout_o    one-cycle pulse when a VSync wait timed out
module paper_mode_seq #(
  parameter int unsigned         CfgWidth     = 64,
  parameter logic [CfgWidth-1:0] CfgReset     = '0,
  parameter int unsigned         SerRstCycles = 16,
  parameter int unsigned         SettleFrames = 2,
  parameter int unsigned         VsTimeout    = 2**20
) (
  input  logic                px_clk_i,
  input  logic                rst_i,
`ifdef PAPER_MODE_SEQ_ABORT_EN
  input  logic                abort_i,
`endif
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [CfgWidth-1:0] req_cfg_i,
  input  logic                vsync_i,
  output logic [CfgWidth-1:0] cfg_o,
  output logic                cfg_load_o,
  output logic                ser_rst_o,
  output logic                blank_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                timeout_o
);

  localparam int unsigned TmoW = $clog2(VsTimeout + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    BLANK   = 3'd2,
    SER_RST = 3'd3,
    LOAD    = 3'd4,
    SETTLE  = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t              state_reg, state_next;
  logic [CfgWidth-1:0] cfg_reg;
  logic [CfgWidth-1:0] pend_reg;
  logic                vsync_q_reg;
  logic [TmoW-1:0]     tmo_cnt_reg;
  logic [7:0]          ser_cnt_reg;
  logic [3:0]          frm_cnt_reg;
  logic                timeout_reg;

  logic vs_rise;
  logic watching;
  logic tmo_hit;
  logic frame_evt;
  logic abort_hit;
  logic abort_now;

`ifdef PAPER_MODE_SEQ_ABORT_EN
  assign abort_hit = abort_i;
`else
  assign abort_hit = 1'b0;
`endif

  // Edges are only meaningful while waiting on VSync; the handshake cycle
  // is IDLE, so a rise coinciding with the handshake is never counted.
  assign vs_rise   = vsync_i & ~vsync_q_reg;
  assign watching  = (state_reg == WAIT_VS) || (state_reg == SETTLE);
  // The last allowed cycle of a wait: VsTimeout cycles have elapsed
  // without an edge once the counter has reached VsTimeout-1.
  assign tmo_hit   = watching && !vs_rise && (tmo_cnt_reg == TmoW'(VsTimeout - 1));
  assign frame_evt = watching && (vs_rise || tmo_hit);
  assign abort_now = (state_reg == WAIT_VS) && abort_hit;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (req_valid_i) state_next = WAIT_VS;
      WAIT_VS: begin
        if (abort_hit)      state_next = IDLE;
        else if (frame_evt) state_next = BLANK;
      end
      BLANK:   state_next = SER_RST;
      SER_RST: if (ser_cnt_reg == 8'(SerRstCycles - 1)) state_next = LOAD;
      LOAD:    state_next = (SettleFrames == 0) ? DONE : SETTLE;
      SETTLE:  if (frame_evt && (frm_cnt_reg == 4'(SettleFrames - 1))) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge px_clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      cfg_reg     <= CfgReset;
      pend_reg    <= '0;
      vsync_q_reg <= 1'b0;
      tmo_cnt_reg <= '0;
      ser_cnt_reg <= '0;
      frm_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      vsync_q_reg <= vsync_i;

      if ((state_reg == IDLE) && req_valid_i) begin
        pend_reg <= req_cfg_i;
      end else if (abort_now) begin
        pend_reg <= '0;
      end

      if ((state_reg == SER_RST) && (state_next == LOAD)) begin
        cfg_reg <= pend_reg;
      end

      // Held at zero outside the wait states, so every entry starts from
      // zero; restarts on each counted edge and saturates at VsTimeout.
      if (!watching || frame_evt) begin
        tmo_cnt_reg <= '0;
      end else if (tmo_cnt_reg != TmoW'(VsTimeout)) begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end

      if (state_reg == SER_RST) ser_cnt_reg <= ser_cnt_reg + 1'b1;
      else                      ser_cnt_reg <= '0;

      if (state_reg != SETTLE)  frm_cnt_reg <= '0;
      else if (frame_evt)       frm_cnt_reg <= frm_cnt_reg + 1'b1;

      timeout_reg <= tmo_hit && !abort_now;
    end
  end

  assign req_ready_o = (state_reg == IDLE);
  assign busy_o      = (state_reg != IDLE);
  assign blank_o     = (state_reg == BLANK) || (state_reg == SER_RST) ||
                       (state_reg == LOAD)  || (state_reg == SETTLE);
  assign ser_rst_o   = (state_reg == SER_RST);
  assign cfg_load_o  = (state_reg == LOAD);
  assign done_o      = (state_reg == DONE);
  assign timeout_o   = timeout_reg;
  assign cfg_o       = cfg_reg;

endmodule

// File: doc/paper_mode_seq.md
PAPER_MODE_SEQ -- requirements
Module: paper_mode_seq

Interface
REQ-001 SHALL have parameter CfgWidth, default 64: width of the opaque video-mode configuration word.
REQ-002 SHALL have parameter CfgReset, default 0: value of cfg_o after reset.
REQ-003 SHALL have parameter SerRstCycles, default 16, legal range 1..255: number of cycles ser_rst_o is held.
REQ-004 SHALL have parameter SettleFrames, default 2, legal range 0..15: number of VSync rising edges waited after the load.
REQ-005 SHALL have parameter VsTimeout, default 2**20: number of cycles the block waits for a VSync edge before giving up.
REQ-006 SHALL have port px_clk_i, in, 1 bit: pixel clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_i, in, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have ports req_valid_i (in, 1) and req_ready_o (out, 1): mode-change request handshake.
REQ-009 SHALL have port req_cfg_i, in, CfgWidth: requested configuration, sampled on handshake.
REQ-010 SHALL have port vsync_i, in, 1: VSync from the timing generator.
REQ-011 SHALL have port cfg_o, out, CfgWidth: active configuration to the timing generator.
REQ-012 SHALL have port cfg_load_o, out, 1: single-cycle load strobe.
REQ-013 SHALL have port ser_rst_o, out, 1: reset to the TMDS encoder and serializers.
REQ-014 SHALL have port blank_o, out, 1: forces the output to blank.
REQ-015 SHALL have ports busy_o, done_o and timeout_o, out, 1 bit each: status outputs.

Function
REQ-016 SHALL implement the states IDLE, WAIT_VS, BLANK, SER_RST, LOAD, SETTLE and DONE, with every output except cfg_o a Moore decode of the registered state.
REQ-017 In IDLE, req_ready_o SHALL be 1; req_valid_i&req_ready_o SHALL capture req_cfg_i into a pending register and move to WAIT_VS on the next edge.
REQ-018 In every state other than IDLE, req_ready_o SHALL be 0, req_valid_i SHALL be ignored and busy_o SHALL be 1.
REQ-019 Edge detect: vs_rise = vsync_i & ~vsync_q, where vsync_q is vsync_i registered; vs_rise SHALL be evaluated only in WAIT_VS and SETTLE.
REQ-020 WAIT_VS SHALL go to BLANK on vs_rise; if VsTimeout cycles elapse without vs_rise, it SHALL go to BLANK and pulse timeout_o for one cycle.
REQ-021 BLANK SHALL last exactly 1 cycle, then go to SER_RST.
REQ-022 blank_o SHALL be 1 in BLANK, SER_RST, LOAD and SETTLE, and 0 elsewhere.
REQ-023 SER_RST SHALL last exactly SerRstCycles cycles with ser_rst_o=1, then go to LOAD.
REQ-024 ser_rst_o SHALL be 0 in every state other than SER_RST.
REQ-025 cfg_o SHALL take the pending value on the edge entering LOAD.
REQ-026 cfg_load_o SHALL be 1 only in LOAD; LOAD SHALL last exactly 1 cycle.
REQ-027 LOAD SHALL go to SETTLE, or directly to DONE if SettleFrames==0.
REQ-028 SETTLE SHALL count vs_rise events and go to DONE after SettleFrames of them.
REQ-029 In SETTLE, each frame SHALL be timeout-guarded as in WAIT_VS; a timeout SHALL count as an edge and pulse timeout_o.
REQ-030 DONE SHALL last 1 cycle with done_o=1, blank_o=0 and busy_o=1, then go to IDLE.
REQ-031 A vs_rise in the handshake cycle SHALL NOT be counted.
REQ-032 The timeout counter SHALL be $clog2(VsTimeout+1) bits wide, clear on entering WAIT_VS or SETTLE and on each counted edge, and saturate without wrap-around.

Reset
REQ-033 While rst_i=1, the state SHALL be IDLE, cfg_o SHALL be CfgReset, the pending register, vsync_q and all counters SHALL be 0, and cfg_load_o, ser_rst_o, blank_o, busy_o, done_o and timeout_o SHALL be 0.
REQ-034 A reset in any state SHALL abandon the change and SHALL NOT emit cfg_load_o or done_o.
REQ-035 req_ready_o SHALL be 1 in the first cycle after rst_i falls.

Configuration
REQ-036 With macro PAPER_MODE_SEQ_ABORT_EN defined, the block SHALL have input abort_i (1 bit); abort_i=1 in WAIT_VS SHALL return the block to IDLE next cycle, discard the pending config and leave cfg_o unchanged, with no done_o.
REQ-037 With PAPER_MODE_SEQ_ABORT_EN defined, abort_i SHALL be ignored in all states other than WAIT_VS.
REQ-038 Without PAPER_MODE_SEQ_ABORT_EN, the abort_i port SHALL be absent and the state machine SHALL be as in REQ-016 to REQ-032.

Verification (SerRstCycles=4, SettleFrames=2, VsTimeout=100, CfgWidth=64)
REQ-039 Normal change: handshake with cfg 0xA5, vsync rising 10 cycles later -> BLANK 1 cycle, ser_rst_o high exactly 4 cycles, cfg_load_o high 1 cycle with cfg_o=0xA5, blank_o stays high until 2 further vsync edges, then done_o for 1 cycle with blank_o=0.
REQ-040 Timeout: handshake with vsync_i held 0 -> timeout_o pulses 100 cycles after WAIT_VS entry, sequence proceeds, and done_o arrives after two more 100-cycle timeouts.
REQ-041 Busy rejection: req_valid_i held high with cfg 0x11 during a change to 0x22 -> req_ready_o=0 throughout; afterwards 0x11 is accepted in IDLE and cfg_o ends as 0x11.
REQ-042 Reset mid-operation: rst_i asserted 2 cycles into SER_RST -> next cycle all outputs are at reset values, cfg_o=CfgReset, and no cfg_load_o or done_o occurs.
REQ-043 Edge alignment: vsync rising in the handshake cycle -> ignored; the next rising edge triggers BLANK.
REQ-044 Abort (macro defined): abort_i=1 in WAIT_VS -> IDLE next cycle, cfg_o unchanged, no strobes.
